psx_button_events: RTL

- Sits directly downstream of the PSX console controller and consumes its raw 16-bit active-low button_state word.
- Synchronises that word into the system clock domain and debounces each button independently.
- Produces debounced active-high levels and one-cycle press/release pulses.
- Queues press/release events in a small valid/ready FIFO for the game logic (e.g. jump/duck handling).

---
 rtl/psx_button_events.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/psx_button_events.sv
// psx_button_events: synchronises and debounces the PSX controller's active-low
// button word, produces debounced levels and one-cycle press/release pulses,
// and queues press/release events in a small valid/ready FIFO.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   button_state  raw active-low button word (0 = held), asynchronous to clk
//   pressed       debounced active-high button levels
//   press_pulse   one-cycle pulse per button when pressed[i] rises
//   release_pulse one-cycle pulse per button when pressed[i] falls
//   evt_valid     FIFO head holds an event
//   evt_ready     consumer accepts the head event this cycle
//   evt_data      {1 = press / 0 = release, button index[3:0]}
//   evt_overflow  sticky flag, set when an event is coalesced
module psx_button_events #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] button_state,
    output logic [15:0] pressed,
    output logic [15:0] press_pulse,
    output logic [15:0] release_pulse,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [4:0]  evt_data,
    output logic        evt_overflow
);

    localparam int unsigned NB    = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    logic [NB-1:0]    sync_m, sync_n, raw;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    pressed_d;
    logic [NB-1:0]    pend_p, pend_r, pend_p_d, pend_r_d, clr_p, clr_r;
    logic             sel_valid, sel_press;
    logic [3:0]       sel_idx;
    logic             pop, push, full, ovf_d, valid_d;
    logic [4:0]       push_data, head_d;
    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_d, wr_ptr_d;
    logic [OCC_W-1:0] occ, occ_d, occ_after_pop;

    assign raw = ~sync_n;

    // Per-button debounce: count consecutive disagreeing cycles, flip on the last.
    always_comb begin
        pressed_d = pressed;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (raw[i] != pressed[i]) begin
                if (cnt_q[i] == CNT_MAX) pressed_d[i] = raw[i];
                else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Arbiter: lowest pending press first, else lowest pending release.
    always_comb begin
        sel_valid = 1'b0;
        sel_press = 1'b0;
        sel_idx   = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pend_r[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 4'(i);
            end
        end
        for (int i = NB - 1; i >= 0; i--) begin
            if (pend_p[i]) begin
                sel_valid = 1'b1;
                sel_press = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    // Pending masks, overflow detection and FIFO bookkeeping.
    always_comb begin
        pop       = evt_valid & evt_ready;
        full      = (occ == DEPTH_C);
        push      = sel_valid & (~full | pop);
        push_data = {sel_press, sel_idx};
        clr_p     = '0;
        clr_r     = '0;
        if (push) begin
            if (sel_press) clr_p[sel_idx] = 1'b1;
            else           clr_r[sel_idx] = 1'b1;
        end
        // A pulse on a bit still pending (and not leaving now) is coalesced.
        ovf_d    = evt_overflow
                 | (|(press_pulse & pend_p & ~clr_p))
                 | (|(release_pulse & pend_r & ~clr_r));
        pend_p_d = (pend_p & ~clr_p) | press_pulse;
        pend_r_d = (pend_r & ~clr_r) | release_pulse;

        occ_d = occ;
        if (push && !pop)      occ_d = occ + OCC_W'(1);
        else if (pop && !push) occ_d = occ - OCC_W'(1);
        rd_ptr_d = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_d = push ? wr_ptr + PTR_W'(1) : wr_ptr;

        // Registered head: next entry in memory, or the pushed one if the FIFO drains to it.
        occ_after_pop = occ - OCC_W'(pop);
        if (occ_after_pop == '0) head_d = push ? push_data : 5'd0;
        else                     head_d = mem[rd_ptr_d];
        valid_d = (occ_d != '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m        <= 16'hFFFF;
            sync_n        <= 16'hFFFF;
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            pend_p        <= '0;
            pend_r        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            evt_valid     <= 1'b0;
            evt_data      <= '0;
            evt_overflow  <= 1'b0;
        end else begin
            sync_m        <= button_state;
            sync_n        <= sync_m;
            pressed       <= pressed_d;
            press_pulse   <= pressed_d & ~pressed;
            release_pulse <= ~pressed_d & pressed;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            pend_p        <= pend_p_d;
            pend_r        <= pend_r_d;
            wr_ptr        <= wr_ptr_d;
            rd_ptr        <= rd_ptr_d;
            occ           <= occ_d;
            evt_valid     <= valid_d;
            evt_data      <= head_d;
            evt_overflow  <= ovf_d;
        end
    end

    // Event storage; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule
